// File: rtl/ex_stage.sv
// Execute stage: ALU/address result, Z/N flags, branch/jump resolution and the
// EX/MEM pipeline register, with wrong-path squashing after a taken redirect.
//
// state  | meaning
// -------+------------------------------------------------------------------
// RUN    | normal issue; a taken branch/jump redirects fetch
// SQUASH | wrong-path shadow; valid instructions become bubbles, count drops
module ex_stage #(
    parameter int DW     = 32,
    parameter int RW     = 6,
    parameter int SHADOW = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          stall,
    input  logic          valid_in,
    input  logic          branch,
    input  logic          brn_sel,
    input  logic          jump,
    input  logic          jumpMem,
    input  logic          memRead,
    input  logic          memToReg,
    input  logic          memWrite,
    input  logic          aluSrc,
    input  logic          regWrt,
    input  logic          svpc,
    input  logic          add,
    input  logic          sub,
    input  logic          inc,
    input  logic          neg,
    input  logic [DW-1:0] immGen,
    input  logic [RW-1:0] rd,
    input  logic [DW-1:0] rs1,
    input  logic [DW-1:0] rs2,
    input  logic [DW-1:0] PC,
    output logic [DW-1:0] alu_result,
    output logic [DW-1:0] store_data,
    output logic [RW-1:0] rd_out,
    output logic          memRead_out,
    output logic          memWrite_out,
    output logic          memToReg_out,
    output logic          regWrt_out,
    output logic          jumpMem_out,
    output logic          flag_z,
    output logic          flag_n,
    output logic          redirect,
    output logic [DW-1:0] redirect_pc
);

    localparam int CW = (SHADOW < 1) ? 1 : $clog2(SHADOW + 1);
    localparam logic [CW-1:0] SHADOW_C = CW'(SHADOW);

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_SQUASH = 1'b1
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;

    logic [DW-1:0] r_alu_result;
    logic [DW-1:0] r_store_data;
    logic [RW-1:0] r_rd;
    logic          r_mem_read;
    logic          r_mem_write;
    logic          r_mem_to_reg;
    logic          r_reg_wrt;
    logic          r_jump_mem;
    logic          r_flag_z;
    logic          r_flag_n;
    logic          r_redirect;
    logic [DW-1:0] r_redirect_pc;

    logic [DW-1:0] w_opb;
    logic [DW-1:0] w_result;
    logic          w_live;
    logic          w_alu_op;
    logic          w_cond;
    logic          w_taken;
    logic          w_ctl_en;

    assign w_live   = valid_in & (r_state == ST_RUN);
    assign w_opb    = aluSrc ? immGen : rs2;
    assign w_alu_op = add | sub | inc | neg;
    // Branches test the flags already registered, not this cycle's result.
    assign w_cond   = brn_sel ? r_flag_n : r_flag_z;
    assign w_taken  = w_live & (jump | (branch & w_cond));
    assign w_ctl_en = w_live & ~branch & ~jump;

    always_comb begin
        w_result = rs1;
        if (svpc) begin
            w_result = PC + immGen;
        end else if (add) begin
            w_result = rs1 + w_opb;
        end else if (sub) begin
            w_result = rs1 - w_opb;
        end else if (inc) begin
            w_result = rs1 + immGen;
        end else if (neg) begin
            w_result = '0 - rs1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_RUN;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        if (!stall) begin
            case (r_state)
                ST_RUN: begin
                    if (w_taken && (SHADOW > 0)) begin
                        w_state_nxt = ST_SQUASH;
                        w_cnt_nxt   = SHADOW_C;
                    end
                end
                ST_SQUASH: begin
                    // Only real instructions consume the shadow; bubbles pass free.
                    if (valid_in) begin
                        w_cnt_nxt = r_cnt - 1'b1;
                        if (r_cnt <= CW'(1)) begin
                            w_cnt_nxt   = '0;
                            w_state_nxt = ST_RUN;
                        end
                    end
                end
                default: begin
                    w_state_nxt = ST_RUN;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_alu_result  <= '0;
            r_store_data  <= '0;
            r_rd          <= '0;
            r_mem_read    <= 1'b0;
            r_mem_write   <= 1'b0;
            r_mem_to_reg  <= 1'b0;
            r_reg_wrt     <= 1'b0;
            r_jump_mem    <= 1'b0;
            r_flag_z      <= 1'b0;
            r_flag_n      <= 1'b0;
            r_redirect    <= 1'b0;
            r_redirect_pc <= '0;
        end else if (stall) begin
            r_redirect <= 1'b0;
        end else begin
            r_alu_result <= w_result;
            r_store_data <= rs2;
            r_rd         <= rd;
            r_mem_read   <= w_ctl_en & memRead;
            r_mem_write  <= w_ctl_en & memWrite;
            r_mem_to_reg <= w_ctl_en & memToReg;
            r_reg_wrt    <= w_ctl_en & regWrt;
            r_jump_mem   <= w_live & jumpMem & ~jump;
            if (w_live && w_alu_op) begin
                r_flag_z <= (w_result == '0);
                r_flag_n <= w_result[DW-1];
            end
            r_redirect <= w_taken;
            if (w_taken) begin
                r_redirect_pc <= rs1;
            end
        end
    end

    assign alu_result   = r_alu_result;
    assign store_data   = r_store_data;
    assign rd_out       = r_rd;
    assign memRead_out  = r_mem_read;
    assign memWrite_out = r_mem_write;
    assign memToReg_out = r_mem_to_reg;
    assign regWrt_out   = r_reg_wrt;
    assign jumpMem_out  = r_jump_mem;
    assign flag_z       = r_flag_z;
    assign flag_n       = r_flag_n;
    assign redirect     = r_redirect;
    assign redirect_pc  = r_redirect_pc;

endmodule

// File: tb/tb_ex_stage.sv
// Bench for ex_stage: directed sequences plus random instructions, scored
// against a behavioural model through an expectation queue.
module tb_ex_stage;

    localparam int SHADOW = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall, valid_in, branch, brn_sel, jump, jumpMem;
    logic        memRead, memToReg, memWrite, aluSrc, regWrt, svpc;
    logic        add, sub, inc, neg;
    logic [31:0] immGen, rs1, rs2, PC;
    logic [5:0]  rd;

    logic [31:0] alu_result, store_data, redirect_pc;
    logic [5:0]  rd_out;
    logic        memRead_out, memWrite_out, memToReg_out, regWrt_out, jumpMem_out;
    logic        flag_z, flag_n, redirect;

    typedef struct packed {
        logic [31:0] res;
        logic [31:0] sd;
        logic [31:0] rpc;
        logic [5:0]  rd;
        logic        mr, mw, mt, rw, jm, fz, fn, rdr;
    } exp_t;

    exp_t q[$];
    exp_t m_out;
    int   shadow_left;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    ex_stage #(.DW(32), .RW(6), .SHADOW(SHADOW)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .valid_in(valid_in),
        .branch(branch), .brn_sel(brn_sel), .jump(jump), .jumpMem(jumpMem),
        .memRead(memRead), .memToReg(memToReg), .memWrite(memWrite),
        .aluSrc(aluSrc), .regWrt(regWrt), .svpc(svpc),
        .add(add), .sub(sub), .inc(inc), .neg(neg),
        .immGen(immGen), .rd(rd), .rs1(rs1), .rs2(rs2), .PC(PC),
        .alu_result(alu_result), .store_data(store_data), .rd_out(rd_out),
        .memRead_out(memRead_out), .memWrite_out(memWrite_out),
        .memToReg_out(memToReg_out), .regWrt_out(regWrt_out),
        .jumpMem_out(jumpMem_out), .flag_z(flag_z), .flag_n(flag_n),
        .redirect(redirect), .redirect_pc(redirect_pc)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic chk_out(input exp_t e);
        chk("alu_result", alu_result, e.res);
        chk("store_data", store_data, e.sd);
        chk("rd_out", {26'd0, rd_out}, {26'd0, e.rd});
        chk("memRead_out", {31'd0, memRead_out}, {31'd0, e.mr});
        chk("memWrite_out", {31'd0, memWrite_out}, {31'd0, e.mw});
        chk("memToReg_out", {31'd0, memToReg_out}, {31'd0, e.mt});
        chk("regWrt_out", {31'd0, regWrt_out}, {31'd0, e.rw});
        chk("jumpMem_out", {31'd0, jumpMem_out}, {31'd0, e.jm});
        chk("flag_z", {31'd0, flag_z}, {31'd0, e.fz});
        chk("flag_n", {31'd0, flag_n}, {31'd0, e.fn});
        chk("redirect", {31'd0, redirect}, {31'd0, e.rdr});
        chk("redirect_pc", redirect_pc, e.rpc);
    endtask

    // Monitor: the stage presents a new EX/MEM word every cycle.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk_out(e);
            end
        end
    end

    // Reference model: what the EX/MEM register must hold after this cycle.
    task automatic model_push();
        logic [31:0] b, r;
        logic        live, ctl, taken;
        if (stall) begin
            m_out.rdr = 1'b0;
        end else begin
            live = valid_in && (shadow_left == 0);
            b = aluSrc ? immGen : rs2;
            if (svpc)      r = PC + immGen;
            else if (add)  r = rs1 + b;
            else if (sub)  r = rs1 - b;
            else if (inc)  r = rs1 + immGen;
            else if (neg)  r = 32'd0 - rs1;
            else           r = rs1;
            taken = live && (jump || (branch && (brn_sel ? m_out.fn : m_out.fz)));
            ctl   = live && !branch && !jump;
            m_out.res = r;
            m_out.sd  = rs2;
            m_out.rd  = rd;
            m_out.mr  = ctl && memRead;
            m_out.mw  = ctl && memWrite;
            m_out.mt  = ctl && memToReg;
            m_out.rw  = ctl && regWrt;
            m_out.jm  = live && jumpMem && !jump;
            if (live && (add || sub || inc || neg)) begin
                m_out.fz = (r == 32'd0);
                m_out.fn = r[31];
            end
            m_out.rdr = taken;
            if (taken) m_out.rpc = rs1;
            if (taken) shadow_left = SHADOW;
            else if (shadow_left > 0 && valid_in) shadow_left--;
        end
        q.push_back(m_out);
    endtask

    task automatic clr();
        {stall, valid_in, branch, brn_sel, jump, jumpMem} = '0;
        {memRead, memToReg, memWrite, aluSrc, regWrt, svpc} = '0;
        {add, sub, inc, neg} = '0;
        immGen = 32'd0; rs1 = 32'd0; rs2 = 32'd0; PC = 32'd0; rd = 6'd0;
    endtask

    task automatic step();
        model_push();
        @(negedge clk);
    endtask

    task automatic alu_op(input int k, input logic [31:0] a, input logic [31:0] bb);
        clr();
        valid_in = 1'b1; regWrt = 1'b1; rd = 6'($urandom_range(1, 63));
        rs1 = a; rs2 = bb;
        case (k)
            0: add = 1'b1;
            1: sub = 1'b1;
            2: inc = 1'b1;
            default: neg = 1'b1;
        endcase
    endtask

    task automatic do_reset_check();
        rst_n = 1'b0;
        #1;
        chk("reset alu_result", alu_result, 32'd0);
        chk("reset regWrt_out", {31'd0, regWrt_out}, 32'd0);
        chk("reset redirect", {31'd0, redirect}, 32'd0);
        chk("reset flags", {30'd0, flag_z, flag_n}, 32'd0);
        chk("reset redirect_pc", redirect_pc, 32'd0);
        m_out = '0;
        shadow_left = 0;
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic rand_instr();
        int k;
        clr();
        k        = $urandom_range(0, 10);
        valid_in = ($urandom_range(0, 5) != 0);
        stall    = ($urandom_range(0, 6) == 0);
        rs1      = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 2)) : $urandom;
        rs2      = ($urandom_range(0, 3) == 0) ? rs1 : $urandom;
        immGen   = ($urandom_range(0, 2) == 0) ? 32'd1 : $urandom;
        PC       = $urandom;
        rd       = 6'($urandom);
        aluSrc   = 1'($urandom);
        case (k)
            0: begin add = 1'b1; regWrt = 1'b1; end
            1: begin sub = 1'b1; regWrt = 1'b1; end
            2: begin inc = 1'b1; regWrt = 1'b1; end
            3: begin neg = 1'b1; regWrt = 1'b1; end
            4: begin svpc = 1'b1; regWrt = 1'b1; end
            5: begin memRead = 1'b1; memToReg = 1'b1; regWrt = 1'b1; end
            6: memWrite = 1'b1;
            7, 8: begin branch = 1'b1; brn_sel = 1'($urandom); end
            9: jump = 1'b1;
            default: begin jumpMem = 1'b1; jump = 1'($urandom); end
        endcase
    endtask

    initial begin
        clr();
        m_out = '0;
        shadow_left = 0;
        @(negedge clk);
        do_reset_check();

        // 1: 5-5 -> zero result, Z set
        alu_op(1, 32'd5, 32'd5); rd = 6'd3; step();
        // 2: neg 1 -> all ones, N set; BRN taken to 0x40
        alu_op(3, 32'd1, 32'd0); step();
        clr(); valid_in = 1'b1; branch = 1'b1; brn_sel = 1'b1; rs1 = 32'h40; regWrt = 1'b1; step();
        // 3: two shadowed adds, then a live one
        alu_op(0, 32'd7, 32'd8); step();
        clr(); step();
        alu_op(0, 32'd9, 32'd1); step();
        alu_op(0, 32'd2, 32'd3); step();
        // 4: Z clear, BRZ not taken; inc wraps to zero
        alu_op(0, 32'd1, 32'd1); step();
        clr(); valid_in = 1'b1; branch = 1'b1; rs1 = 32'h80; step();
        alu_op(0, 32'd4, 32'd4); step();
        alu_op(2, 32'hFFFF_FFFF, 32'd0); immGen = 32'd1; step();
        // 5: stall mid-stream, then jump held under stall
        alu_op(3, 32'd6, 32'd0); step();
        for (int i = 0; i < 3; i++) begin
            alu_op(0, 32'd1, 32'd2); stall = 1'b1; step();
        end
        clr(); valid_in = 1'b1; jump = 1'b1; rs1 = 32'h1234; stall = 1'b1; step();
        stall = 1'b1; step();
        stall = 1'b0; step();
        clr(); step();
        for (int i = 0; i < 3; i++) begin
            alu_op(0, 32'd3, 32'd3); step();
        end
        // 6: reset while one shadow slot remains
        clr(); valid_in = 1'b1; jump = 1'b1; rs1 = 32'h500; step();
        alu_op(0, 32'd1, 32'd1); step();
        do_reset_check();
        alu_op(0, 32'd10, 32'd20); rd = 6'd9; step();

        for (int i = 0; i < 600; i++) begin
            rand_instr();
            step();
        end
        clr();
        step();
        step();

        chk("scoreboard drained", 32'(q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute stage directly downstream of the ID/EX pipeline register. It consumes that register's decoded controls and operands.
- It computes the ALU/address result, keeps the Z/N condition flags, resolves branches and jumps, and drives the EX/MEM pipeline register that feeds the memory stage.
- On a taken branch or jump it redirects fetch and squashes the wrong-path instructions already in flight.

Parameters:
- DW, 32, datapath/operand/PC width
- RW, 6, register specifier width
- SHADOW, 2, number of younger instructions squashed after a taken redirect

Ports:
- clk  in  1  pipeline clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- stall  in  1  hold: EX/MEM outputs, flags and squash counter keep their values
- valid_in  in  1  instruction presented from ID/EX is real (0 = bubble)
- branch  in  1  conditional branch
- brn_sel  in  1  branch condition select: 0 = BRZ (Z flag), 1 = BRN (N flag)
- jump  in  1  unconditional jump to register A
- jumpMem  in  1  jump through memory; passed to the memory stage
- memRead, memToReg, memWrite, aluSrc, regWrt, svpc  in  1 each  decoded controls from ID/EX
- add, sub, inc, neg  in  1 each  one-hot ALU op select
- immGen  in  DW  sign-extended immediate
- rd  in  RW  destination register
- rs1  in  DW  operand A value
- rs2  in  DW  operand B value
- PC  in  DW  PC of this instruction
- alu_result  out  DW  registered result
- store_data  out  DW  registered rs2
- rd_out  out  RW  registered rd
- memRead_out, memWrite_out, memToReg_out, regWrt_out, jumpMem_out  out  1 each  registered controls
- flag_z, flag_n  out  1 each  condition flags
- redirect  out  1  one-cycle pulse: fetch must load redirect_pc
- redirect_pc  out  DW  redirect target

Behaviour:
- Reset (async, rst_n=0): every output is 0, the squash counter is 0, and the state is RUN. Release is synchronous to clk.
- Operand B = aluSrc ? immGen : rs2.
- Result, first matching term wins (priority order):
  - svpc: PC + immGen
  - add: rs1 + B
  - sub: rs1 - B
  - inc: rs1 + immGen
  - neg: 0 - rs1
  - otherwise: rs1 (load/store address and jump target)
- All arithmetic is modulo 2^DW; carry/overflow are discarded.
- live = valid_in & (state==RUN).
- Flags:
  - Updated at the clock edge only when live, !stall and one of add/sub/inc/neg is set.
  - Z = (result==0), N = result[DW-1].
  - svpc, loads and branches leave the flags unchanged.
- Branch decision uses the registered flags, i.e. the result of the previous ALU instruction. Same-cycle flag updates are not forwarded.
- taken = live & (jump | (branch & (brn_sel ? flag_n : flag_z))).
- Latency: one cycle. EX/MEM outputs, redirect and redirect_pc register at the edge after the inputs are presented.
- When taken (and !stall):
  - redirect pulses 1 for exactly one cycle.
  - redirect_pc = rs1.
  - The state goes to SQUASH with count = SHADOW.
- Branch/jump instructions write back nothing: regWrt_out=0, memRead_out=0, memWrite_out=0.
- State machine:
  - RUN: normal operation; the taken condition goes to SQUASH.
  - SQUASH: each non-stalled cycle with valid_in=1 decrements count. The instruction is converted to a bubble: all _out controls 0, flags held, no redirect. Bubbles (valid_in=0) do not decrement.
  - Return to RUN on the edge at which count reaches 0.
- Bubble / !live: control outputs register 0. Data outputs register their computed values (don't-care).
- stall=1: all registers hold, redirect registers 0, and the counter holds. A stall never duplicates a redirect pulse.
- Simultaneous jumpMem and jump: jump wins in EX; jumpMem_out=0.
- Reset mid-SQUASH: the counter clears, the state is RUN, and no pending redirect survives.

Test Plan:
1. Reset, then rs1=5, rs2=5, sub=1, regWrt=1, rd=3, valid_in=1 -> next cycle alu_result=0, flag_z=1, flag_n=0, regWrt_out=1, rd_out=3.
2. neg with rs1=1 -> alu_result=0xFFFFFFFF, flag_n=1. Then branch=1, brn_sel=1, rs1=0x40 -> redirect=1 for one cycle, redirect_pc=0x40, regWrt_out=0.
3. Taken branch followed by two valid add instructions with regWrt=1 -> both produce regWrt_out=0 with flags unchanged. A third add -> regWrt_out=1.
4. flag_z=0 and branch=1, brn_sel=0 -> redirect stays 0 and no instructions are squashed. Also inc with rs1=0xFFFFFFFF, immGen=1 -> result 0, flag_z=1.
5. stall=1 for 3 cycles mid-stream -> all outputs and flags held constant and redirect=0. Also a taken jump with stall asserted -> exactly one redirect pulse after stall drops.
6. Assert rst_n=0 asynchronously while in SQUASH with count=1 -> outputs 0 immediately. After release, the next valid add has regWrt_out=1 and is not squashed.
